// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter that shares one synchronous FIFO write port
// between NUM_REQ producers; never writes while the FIFO reports full.
//
// state | meaning
// IDLE  | no owner; pick the next pending requester starting at rr_ptr
// BURST | owner holds the port until last, MAX_BURST beats, or it drops req
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          busy,
  output logic                          overflow_err
);
  localparam int OWNER_W = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [OWNER_W-1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx, owner_inc;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d, beat_inc;
  logic [NUM_REQ-1:0]    req_rot;
  logic                  pick_valid, sel_req, sel_last, wr;
  logic [FIFO_WIDTH-1:0] sel_data;

  // Rotate so bit 0 is rr_ptr; the descending scan leaves the lowest offset winning.
  always_comb begin
    req_rot    = NUM_REQ'({req, req} >> rr_ptr_q);
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_valid = 1'b1;
        pick_idx   = OWNER_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWNER_W'(i)) begin
        sel_req  = req[i];
        sel_last = req_last[i];
        sel_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  assign owner_inc = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
  assign beat_inc  = beat_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    grant        = '0;
    ack          = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    busy         = 1'b0;
    wr           = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        busy         = 1'b1;
        fifo_data_in = sel_data;
        // rst gates the write so an abandoned packet never lands a beat.
        wr           = sel_req & ~fifo_full & ~rst;
        fifo_wr_en   = wr;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_q == OWNER_W'(i)) begin
            grant[i] = 1'b1;
            ack[i]   = wr;
          end
        end
        if (wr) begin
          beat_cnt_d = beat_inc;
          if (sel_last || beat_inc == CNT_W'(MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = owner_inc;
          end
        end else if (!sel_req) begin
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      overflow_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      if (fifo_overflow) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, scenario sequences and random
// traffic against a cycle-level reference model plus a FIFO ordering scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 16, MB = 8, DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, req_last, grant, ack;
  logic [N*W-1:0] req_data;
  logic fifo_full, fifo_overflow, fifo_wr_en, busy, overflow_err;
  logic [W-1:0] fifo_data_in;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .grant(grant), .ack(ack), .fifo_full(fifo_full), .fifo_overflow(fifo_overflow),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .busy(busy),
    .overflow_err(overflow_err)
  );

  typedef struct {
    logic rst; logic [N-1:0] req, last; logic full, ovf;
    logic [N-1:0] eg, ea; logic ew, eb, eo;
  } vec_t;

  vec_t tab[$];
  vec_t dummy;

  int n_checks = 0, n_fail = 0;
  bit m_busy, m_ovf;
  int m_owner, m_ptr, m_cnt;
  logic [W-1:0] fifo_q[$];
  int seq[N], exp_seq[N], pkt_beat[N];
  bit full_force;
  int pop_pct;
  logic [N-1:0] s_grant, s_ack;
  logic s_busy, s_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] l,
                     input logic f, input logic o, input logic [N-1:0] eg,
                     input logic [N-1:0] ea, input logic ew, input logic eb, input logic eo);
    vec_t v;
    v.rst = r; v.req = rq; v.last = l; v.full = f; v.ovf = o;
    v.eg = eg; v.ea = ea; v.ew = ew; v.eb = eb; v.eo = eo;
    tab.push_back(v);
  endtask

  function automatic logic [N*W-1:0] lanes();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = {4'(i), 12'(seq[i])};
    return d;
  endfunction

  task automatic pop_check();
    logic [W-1:0] w;
    int id;
    w  = fifo_q.pop_front();
    id = int'(w[15:12]);
    if (id < N) begin
      check("fifo_order", 64'(w[11:0]), 64'(12'(exp_seq[id])));
      exp_seq[id]++;
    end else begin
      check("fifo_lane", 64'(id), 64'(0));
    end
  endtask

  // One clock: sample combinational outputs mid-cycle, then advance FIFO and model.
  task automatic cycle(input bit use_tab, input vec_t t);
    logic [N-1:0] eg, ea;
    logic ew, eb;
    logic [W-1:0] ed;
    bit found;
    if (!full_force) fifo_full = (fifo_q.size() >= DEPTH);
    #4;
    eg = '0; ea = '0; ew = 1'b0; eb = 1'b0; ed = '0;
    if (m_busy) begin
      eg[m_owner] = 1'b1;
      eb = 1'b1;
      ed = req_data[m_owner*W +: W];
      if (req[m_owner] && !fifo_full && !rst) begin
        ew = 1'b1;
        ea[m_owner] = 1'b1;
      end
    end
    check("grant", 64'(grant), 64'(eg));
    check("ack", 64'(ack), 64'(ea));
    check("wr_en", 64'(fifo_wr_en), 64'(ew));
    check("busy", 64'(busy), 64'(eb));
    check("data_in", 64'(fifo_data_in), 64'(ed));
    check("overflow_err", 64'(overflow_err), 64'(m_ovf));
    if (use_tab) begin
      check("tab_grant", 64'(grant), 64'(t.eg));
      check("tab_ack", 64'(ack), 64'(t.ea));
      check("tab_wr_en", 64'(fifo_wr_en), 64'(t.ew));
      check("tab_busy", 64'(busy), 64'(t.eb));
      check("tab_ovf_err", 64'(overflow_err), 64'(t.eo));
    end
    s_grant = grant; s_ack = ack; s_busy = busy; s_wr = fifo_wr_en;
    if (fifo_wr_en) fifo_q.push_back(fifo_data_in);
    for (int i = 0; i < N; i++)
      if (ack[i]) begin
        seq[i]++;
        pkt_beat[i] = req_last[i] ? 0 : pkt_beat[i] + 1;
      end
    if (fifo_q.size() > 0 && $urandom_range(99) < pop_pct) pop_check();
    // Reference: lock to one producer per packet, rotate fairly after each release.
    if (rst) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++)
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1'b1;
          m_owner = (m_ptr + k) % N;
        end
      if (found) begin m_busy = 1'b1; m_cnt = 0; end
    end else if (ew) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MB) begin m_busy = 1'b0; m_ptr = (m_owner + 1) % N; end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0; m_ptr = (m_owner + 1) % N;
    end
    m_ovf = rst ? 1'b0 : (m_ovf | fifo_overflow);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_last = '0; fifo_overflow = 1'b0; req_data = lanes();
    cycle(1'b0, dummy);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] order[$];
    logic [N-1:0] prev;
    int writes, cyc, acks1, idles;

    dummy = '{default: '0};
    for (int i = 0; i < N; i++) begin seq[i] = 0; exp_seq[i] = 0; pkt_beat[i] = 0; end
    full_force = 1'b0; pop_pct = 100;
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0; fifo_overflow = 1'b0;
    @(posedge clk); #1;
    m_busy = 1'b0; m_ovf = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;

    //  rst req      last     full ovf grant    ack      wr busy oerr
    add(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0001, 1, 1, 0);
    add(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0001, 1, 1, 0);
    add(0, 4'b0001, 4'b0001, 0, 0, 4'b0001, 4'b0001, 1, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1010, 4'b0000, 0, 0, 4'b0010, 4'b0010, 1, 1, 0);
    add(0, 4'b1000, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0, 1, 0);
    add(0, 4'b1000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1000, 4'b1000, 0, 0, 4'b1000, 4'b1000, 1, 1, 0);
    add(0, 4'b0100, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0100, 1, 1, 0);
    add(0, 4'b0100, 4'b0000, 1, 0, 4'b0100, 4'b0000, 0, 1, 0);
    add(0, 4'b0100, 4'b0000, 1, 0, 4'b0100, 4'b0000, 0, 1, 0);
    add(0, 4'b0100, 4'b0100, 0, 0, 4'b0100, 4'b0100, 1, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 0, 1, 4'b0100, 4'b0100, 1, 1, 0);
    add(1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 0, 1, 1);
    add(0, 4'b1111, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 4'b1111, 0, 0, 4'b0001, 4'b0001, 1, 1, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    full_force = 1'b1;
    for (int r = 0; r < tab.size(); r++) begin
      rst = tab[r].rst; req = tab[r].req; req_last = tab[r].last;
      fifo_full = tab[r].full; fifo_overflow = tab[r].ovf; req_data = lanes();
      cycle(1'b1, tab[r]);
    end
    full_force = 1'b0;

    // All four requesting, two-beat packets: fair rotation with one bubble each.
    do_reset();
    for (int i = 0; i < N; i++) pkt_beat[i] = 0;
    writes = 0; prev = '0;
    for (int c = 0; c < 15; c++) begin
      req = 4'b1111;
      for (int i = 0; i < N; i++) req_last[i] = (pkt_beat[i] == 1);
      req_data = lanes();
      cycle(1'b0, dummy);
      if (c < 12 && s_wr) writes++;
      if (s_grant != '0 && s_grant != prev) order.push_back(s_grant);
      prev = s_grant;
    end
    req = '0; req_last = '0;
    check("rr_writes_12cyc", 64'(writes), 64'(8));
    check("rr_order_len", 64'(order.size()), 64'(5));
    if (order.size() == 5) begin
      check("rr_order0", 64'(order[0]), 64'(4'b0001));
      check("rr_order1", 64'(order[1]), 64'(4'b0010));
      check("rr_order2", 64'(order[2]), 64'(4'b0100));
      check("rr_order3", 64'(order[3]), 64'(4'b1000));
      check("rr_order4", 64'(order[4]), 64'(4'b0001));
    end

    // Endless stream from requester 1: forced release every MB beats.
    do_reset();
    cyc = 0; acks1 = 0; idles = 0;
    while (cyc < 60 && acks1 < 20) begin
      req = 4'b0010; req_last = '0; req_data = lanes();
      cycle(1'b0, dummy);
      cyc++;
      if (s_ack[1]) acks1++;
      if (!s_busy) idles++;
    end
    req = '0;
    check("burst_acks", 64'(acks1), 64'(20));
    check("burst_cycles", 64'(cyc), 64'(23));
    check("burst_idles", 64'(idles), 64'(3));

    // Random traffic with a shallow FIFO that drains irregularly.
    do_reset();
    pop_pct = 40;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(299) == 0);
      fifo_overflow = ($urandom_range(499) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(req[i] && !s_ack[i] && $urandom_range(9) != 0))
          req[i] = ($urandom_range(9) < 6);
        req_last[i] = ($urandom_range(3) == 0);
      end
      req_data = lanes();
      cycle(1'b0, dummy);
    end
    rst = 1'b0; req = '0; fifo_overflow = 1'b0;
    while (fifo_q.size() > 0) pop_check();
    writes = 0; acks1 = 0;
    for (int i = 0; i < N; i++) begin writes += seq[i]; acks1 += exp_seq[i]; end
    check("words_written_vs_acked", 64'(acks1), 64'(writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
